// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - interval-timer register map, control bits and sequencer states
package timer_regs_pkg;

  // Timer slave register addresses
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // Control register bit indices
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_START,
    ST_STOP,
    ST_STOP_CLR,
    ST_SNAP_WR,
    ST_SNAP_RL,
    ST_SNAP_RH,
    ST_SNAP_DONE
  } seq_state_e;

  // Control word that starts the timer with the requested mode bits
  function automatic logic [15:0] start_word(input logic cont, input logic ito);
    logic [15:0] w;
    w = '0;
    w[CTRL_START] = 1'b1;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

  // Control word that stops the timer
  function automatic logic [15:0] stop_word();
    logic [15:0] w;
    w = '0;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_host_sequencer.sv
// rtl/timer_host_sequencer.sv - Avalon-MM master that starts/stops/services/snapshots the interval timer
module timer_host_sequencer
  import timer_regs_pkg::*;
#(
  parameter bit CONTINUOUS = 1'b1,
  parameter bit IRQ_EN     = 1'b1,
  parameter int TICK_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              snap_req,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              irq_in,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic              running,
  output logic              busy
);

  localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

  seq_state_e  state, state_nx;
  logic        pend_start, pend_stop, pend_snap;
  logic        want_start, want_stop, want_snap;
  logic [2:0]  addr_nx;
  logic        cs_nx, wn_nx;
  logic [15:0] wdata_nx;
  logic [15:0] snap_lo;
  logic [31:0] snap_hold;

  // A start coinciding with a stop is dropped; live requests join the pending ones
  assign want_stop  = pend_stop | stop;
  assign want_start = pend_start | (start & ~stop);
  assign want_snap  = pend_snap | snap_req;

  // Next-state: IDLE dispatches by priority, every other state lasts one cycle
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (irq_in)          state_nx = ST_CLR;
        else if (want_stop)  state_nx = ST_STOP;
        else if (want_start) state_nx = ST_START;
        else if (want_snap)  state_nx = ST_SNAP_WR;
      end
      ST_STOP:      state_nx = ST_STOP_CLR;
      ST_SNAP_WR:   state_nx = ST_SNAP_RL;
      ST_SNAP_RL:   state_nx = ST_SNAP_RH;
      ST_SNAP_RH:   state_nx = ST_SNAP_DONE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // Bus cycle for the state being entered, registered so it lines up with that state
  always_comb begin
    addr_nx  = REG_STATUS;
    cs_nx    = 1'b0;
    wn_nx    = 1'b1;
    wdata_nx = 16'h0000;
    case (state_nx)
      ST_CLR, ST_STOP_CLR: begin
        cs_nx = 1'b1;
        wn_nx = 1'b0;
      end
      ST_START: begin
        addr_nx  = REG_CONTROL;
        cs_nx    = 1'b1;
        wn_nx    = 1'b0;
        wdata_nx = start_word(CONTINUOUS, IRQ_EN);
      end
      ST_STOP: begin
        addr_nx  = REG_CONTROL;
        cs_nx    = 1'b1;
        wn_nx    = 1'b0;
        wdata_nx = stop_word();
      end
      ST_SNAP_WR: begin
        addr_nx = REG_SNAPL;
        cs_nx   = 1'b1;
        wn_nx   = 1'b0;
      end
      ST_SNAP_RL: addr_nx = REG_SNAPL;
      ST_SNAP_RH: addr_nx = REG_SNAPH;
      default: ;
    endcase
  end

  // State, pending requests and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      pend_start   <= 1'b0;
      pend_stop    <= 1'b0;
      pend_snap    <= 1'b0;
      m_address    <= REG_STATUS;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= 16'h0000;
    end else begin
      state        <= state_nx;
      pend_stop    <= want_stop  & ~((state == ST_IDLE) && (state_nx == ST_STOP));
      pend_start   <= want_start & ~((state == ST_IDLE) && (state_nx == ST_START));
      pend_snap    <= want_snap  & ~((state == ST_IDLE) && (state_nx == ST_SNAP_WR));
      m_address    <= addr_nx;
      m_chipselect <= cs_nx;
      m_write_n    <= wn_nx;
      m_writedata  <= wdata_nx;
    end
  end

  // Tick counting, run flag and snapshot halves, updated at the end of each sequence step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= '0;
      running    <= 1'b0;
      snap_lo    <= 16'h0000;
      snap_hold  <= 32'h0000_0000;
    end else begin
      case (state)
        ST_CLR: begin
          tick_count <= tick_count + TICK_ONE;
          if (!CONTINUOUS) running <= 1'b0;
        end
        ST_START:     running   <= 1'b1;
        ST_STOP:      running   <= 1'b0;
        ST_SNAP_RH:   snap_lo   <= m_readdata;
        ST_SNAP_DONE: snap_hold <= {m_readdata, snap_lo};
        default: ;
      endcase
    end
  end

  // The high half arrives during SNAP_DONE, so the new value is forwarded in that cycle
  assign snap_value = (state == ST_SNAP_DONE) ? {m_readdata, snap_lo} : snap_hold;
  assign snap_valid = (state == ST_SNAP_DONE);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_timer_host_sequencer.sv
// tb/tb_timer_host_sequencer.sv - self-checking bench with an interval-timer slave model
module tb_timer_host_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, snap_req;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;
  logic        irq_in;
  logic [3:0]  tick_count;
  logic [31:0] snap_value;
  logic        snap_valid, running, busy;

  timer_host_sequencer #(.CONTINUOUS(1'b1), .IRQ_EN(1'b1), .TICK_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .snap_req(snap_req),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .irq_in(irq_in),
    .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid),
    .running(running), .busy(busy)
  );

  always #5 clk = ~clk;

  // Timer slave model
  logic [31:0] t_period = 32'h1BED;
  logic [31:0] t_cnt, t_snap, cnt_val;
  logic        t_run, t_irq, irq_force, cnt_load;
  logic [15:0] rd;

  assign irq_in     = t_irq;
  assign m_readdata = rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_run <= 1'b0; t_irq <= 1'b0; t_cnt <= '0; t_snap <= '0; rd <= '0;
    end else begin
      rd <= (m_address == 3'd4) ? t_snap[15:0] :
            (m_address == 3'd5) ? t_snap[31:16] :
            (m_address == 3'd0) ? {15'd0, t_irq} : 16'd0;
      if (t_run) begin
        if (t_cnt == 0) begin t_irq <= 1'b1; t_cnt <= t_period; end
        else t_cnt <= t_cnt - 1;
      end
      if (irq_force) t_irq <= 1'b1;
      if (cnt_load) t_cnt <= cnt_val;
      if (m_chipselect && !m_write_n) begin
        case (m_address)
          3'd0: t_irq <= 1'b0;
          3'd1: begin
            if (m_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
            if (m_writedata[3]) t_run <= 1'b0;
          end
          3'd4: t_snap <= t_cnt;
          default: ;
        endcase
      end
    end
  end

  // Bus monitor
  int wr_cnt = 0, rd_cnt = 0, st_wr_cnt = 0, st_bad = 0, snap_cnt = 0;
  int irq_hi = 0, irq_max = 0;

  always @(negedge clk) begin
    if (m_chipselect && !m_write_n) begin
      wr_cnt++;
      if (m_address == 3'd0) begin
        st_wr_cnt++;
        if (m_writedata != 16'h0) st_bad++;
      end
    end
    if (!m_chipselect && (m_address == 3'd4 || m_address == 3'd5)) rd_cnt++;
    if (snap_valid) snap_cnt++;
    if (irq_in) irq_hi++;
    else begin
      if (irq_hi > irq_max) irq_max = irq_hi;
      irq_hi = 0;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic q);
    @(posedge clk); #1;
    start = s; stop = p; snap_req = q;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; snap_req = 1'b0;
  endtask

  task automatic drain();
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (busy) idle = 0; else idle++;
    end
    if (idle < 3) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: busy=%0b after %0d cycles", busy, n);
    end
    @(posedge clk);
  endtask

  task automatic load_cnt(input logic [31:0] v);
    @(posedge clk); #1;
    cnt_val = v; cnt_load = 1'b1;
    @(posedge clk); #1;
    cnt_load = 1'b0;
  endtask

  task automatic wait_status_writes(input int n, input int bound);
    int s0 = st_wr_cnt;
    int c = 0;
    while (st_wr_cnt - s0 < n && c < bound) begin @(posedge clk); c++; end
    check("status_write_wait", st_wr_cnt - s0, n);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_addr"},  m_address,    0);
    check({tag, "_cs"},    m_chipselect, 0);
    check({tag, "_wn"},    m_write_n,    1);
    check({tag, "_wdata"}, m_writedata,  0);
  endtask

  typedef struct {
    logic        start, stop, snap;
    logic [2:0]  addr;
    logic        cs, wn;
    logic [15:0] wdata;
    logic        busy;
    logic        run;
    int          writes;
    int          reads;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0, r0, p0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 2, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 2, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 2};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 0, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b1, 2, 2};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; snap_req = 1'b0;
    irq_force = 1'b0; cnt_load = 1'b0; cnt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_bus("reset");
    check("reset_tick", tick_count, 0);
    check("reset_snap_value", snap_value, 0);
    check("reset_snap_valid", snap_valid, 0);
    check("reset_running", running, 0);
    check("reset_busy", busy, 0);
    reset_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      pulse(vecs[i].start, vecs[i].stop, vecs[i].snap);
      @(negedge clk);
      check($sformatf("vec%0d_addr", i),  m_address,    vecs[i].addr);
      check($sformatf("vec%0d_cs", i),    m_chipselect, vecs[i].cs);
      check($sformatf("vec%0d_wn", i),    m_write_n,    vecs[i].wn);
      check($sformatf("vec%0d_wdata", i), m_writedata,  vecs[i].wdata);
      check($sformatf("vec%0d_busy", i),  busy,         vecs[i].busy);
      drain();
      check($sformatf("vec%0d_running", i), running, vecs[i].run);
      check($sformatf("vec%0d_writes", i),  wr_cnt - w0, vecs[i].writes);
      check($sformatf("vec%0d_reads", i),   rd_cnt - r0, vecs[i].reads);
    end

    // Three full periods of the running timer
    wait_status_writes(3, 30000);
    drain();
    check("ticks_count", tick_count, 3);
    check("ticks_status_data", st_bad, 0);
    check("ticks_irq_cleared_2cyc", (irq_max <= 2), 1);
    check("ticks_running", running, 1);

    pulse(1'b0, 1'b1, 1'b0);
    drain();
    check("stop_running", running, 0);
    check("stop_tick_unchanged", tick_count, 3);

    // Snapshot with the counter held at 0x0123
    load_cnt(32'h0000_0123);
    p0 = snap_cnt;
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("snap_wr_addr", m_address, 4);
    check("snap_wr_cs", m_chipselect, 1);
    check("snap_wr_wn", m_write_n, 0);
    @(negedge clk);
    check("snap_rl_addr", m_address, 4);
    check("snap_rl_cs", m_chipselect, 0);
    check("snap_rl_wn", m_write_n, 1);
    @(negedge clk);
    check("snap_rh_addr", m_address, 5);
    check("snap_rh_valid", snap_valid, 0);
    @(negedge clk);
    check("snap_done_valid", snap_valid, 1);
    check("snap_done_value", snap_value, 32'h0000_0123);
    @(negedge clk);
    check("snap_after_valid", snap_valid, 0);
    check("snap_after_value", snap_value, 32'h0000_0123);
    drain();
    check("snap_pulse_count", snap_cnt - p0, 1);

    // irq and snap_req in the same cycle
    load_cnt(32'h0000_0456);
    p0 = snap_cnt;
    @(posedge clk); #1;
    irq_force = 1'b1;
    @(posedge clk); #1;
    irq_force = 1'b0; snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    @(negedge clk);
    check("coll_clr_addr", m_address, 0);
    check("coll_clr_cs", m_chipselect, 1);
    check("coll_clr_wn", m_write_n, 0);
    drain();
    check("coll_tick", tick_count, 4);
    check("coll_snap_pulses", snap_cnt - p0, 1);
    check("coll_snap_value", snap_value, 32'h0000_0456);

    // 16 ticks wrap a 4-bit count back to zero
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    t_period = 32'd20;
    check("wrap_tick_after_reset", tick_count, 0);
    pulse(1'b1, 1'b0, 1'b0);
    wait_status_writes(16, 2000);
    pulse(1'b0, 1'b1, 1'b0);
    drain();
    check("wrap_tick", tick_count, 0);
    check("wrap_running", running, 0);
    check("wrap_status_data", st_bad, 0);

    // Reset while SNAP_RL is on the bus
    t_period = 32'h1BED;
    pulse(1'b1, 1'b0, 1'b0);
    drain();
    load_cnt(32'h0000_0789);
    pulse(1'b0, 1'b0, 1'b1);
    drain();
    check("prereset_running", running, 1);
    check("prereset_snap_nonzero", (snap_value != 0), 1);
    p0 = snap_cnt;
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("midsnap_addr", m_address, 4);
    check("midsnap_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_idle_bus("abort");
    check("abort_snap_value", snap_value, 0);
    check("abort_snap_valid", snap_valid, 0);
    check("abort_running", running, 0);
    check("abort_busy", busy, 0);
    check("abort_tick", tick_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_no_snap_pulse", snap_cnt - p0, 0);
    check("abort_snap_held_zero", snap_value, 0);
    check("abort_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
